// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 8N1 serial transmitter: baud divisors for a
// 12 MHz system clock, frame geometry and the transmitter state type.
package uart_tx_pkg;

    // Clock cycles per bit at 12 MHz
    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 312;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    localparam int FRAME_BITS = 10;
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tx_state_t;

    // Start bit in the LSB so it leaves the shift register first.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// Bit-period timer: counts 0..BAUD-1 while enabled and pulses tick on the
// last cycle of each period; held at zero while disabled.
module baudgen_tx #(
    parameter int BAUD = 104
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic tick
);

    localparam int W = $clog2(BAUD);
    localparam logic [W-1:0] CNT_LAST = W'(BAUD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!clk_ena) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = clk_ena && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: accepts a byte on a start strobe while idle and
// shifts start bit, eight data bits LSB-first and a stop bit onto tx.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx,
    output logic       state_dbg
);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [3:0]            bit_cnt;
    logic                  tick;
    logic                  load;
    logic                  clk_ena;
    logic                  last_bit;

    // Timer runs only while busy, so it restarts from zero with every frame.
    baudgen_tx #(
        .BAUD(BAUD)
    ) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (clk_ena),
        .tick    (tick)
    );

    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)             state_nxt = ST_BUSY;
            ST_BUSY: if (tick && last_bit)  state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == ST_IDLE);
        clk_ena   = (state == ST_BUSY);
        state_dbg = (state == ST_BUSY);
        load      = (state == ST_IDLE) && start;
    end

    // Ones shifted in behind the frame leave the line high once the stop bit is done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg   <= '1;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= frame_word(data);
            bit_cnt <= '0;
        end else if (tick) begin
            shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        end
    end

    assign tx = shreg[0];

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUD=4: per-cycle comparison of tx/ready against a
// frame-level model, plus byte decoding of the line against an expected queue.
module tb_uart_tx;

    localparam int BAUD      = 4;
    localparam int FRAME_CYC = 10 * BAUD;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(
        .BAUD(BAUD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data      (data),
        .start     (start),
        .ready     (ready),
        .tx        (tx),
        .state_dbg (state_dbg)
    );

    // Line level k cycles after the accepting edge: bit n = k / BAUD.
    function automatic logic model_tx(input logic [7:0] d, input int k);
        int n;
        n = k / BAUD;
        if (k < 0 || n >= 10) return 1'b1;
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return d[n-1];
    endfunction

    function automatic logic model_ready(input int k);
        return (k < 0) || (k >= FRAME_CYC);
    endfunction

    task automatic test_reset();
        start = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold tx=%b ready=%b expected tx=1 ready=1", tx, ready);
        end
        rstn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d tx=%b ready=%b expected tx=1 ready=1", i, tx, ready);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] d);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL single_pre ready=%b expected 1", ready);
        end
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        data = 8'($urandom);
        for (int k = 0; k <= FRAME_CYC + 2; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== model_tx(d, k) || ready !== model_ready(k)) begin
                failures++;
                $display("FAIL single d=%h k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                         d, k, tx, ready, model_tx(d, k), model_ready(k));
            end
        end
    endtask

    task automatic test_data_change();
        logic [7:0] rx;
        rx = 8'h00;
        @(negedge clk);
        data  = 8'h0A;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        data = 8'hFF;
        for (int k = 0; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            if (k >= BAUD && k < 9 * BAUD && (k % BAUD) == BAUD / 2)
                rx[k / BAUD - 1] = tx;
            checks++;
            if (tx !== model_tx(8'h0A, k) || ready !== model_ready(k)) begin
                failures++;
                $display("FAIL data_change k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                         k, tx, ready, model_tx(8'h0A, k), model_ready(k));
            end
        end
        checks++;
        if (rx !== 8'h0A) begin
            failures++;
            $display("FAIL data_change_decode got=%h expected=0a", rx);
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] d;
        d = 8'($urandom);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= FRAME_CYC + 4; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== model_tx(d, k) || ready !== model_ready(k)) begin
                failures++;
                $display("FAIL ignore_start k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                         k, tx, ready, model_tx(d, k), model_ready(k));
            end
            start = (k == 4 || k == 19);
            data  = 8'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== model_tx(d, k) || ready !== model_ready(k)) begin
                failures++;
                $display("FAIL reset_mid_pre k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                         k, tx, ready, model_tx(d, k), model_ready(k));
            end
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_async tx=%b ready=%b expected tx=1 ready=1", tx, ready);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3 * BAUD * 2; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_tail cycle=%0d tx=%b ready=%b expected tx=1 ready=1", i, tx, ready);
            end
        end
        test_single(8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic exp_tx;
        logic exp_rdy;
        int   j;
        @(negedge clk);
        data  = 8'h41;
        start = 1'b1;
        @(posedge clk);
        #1 data = 8'h42;
        for (int k = 0; k <= 2 * FRAME_CYC + 2; k++) begin
            @(negedge clk);
            if (k <= FRAME_CYC) begin
                exp_tx  = model_tx(8'h41, k);
                exp_rdy = model_ready(k);
            end else begin
                j       = k - (FRAME_CYC + 1);
                exp_tx  = model_tx(8'h42, j);
                exp_rdy = model_ready(j);
            end
            checks++;
            if (tx !== exp_tx || ready !== exp_rdy) begin
                failures++;
                $display("FAIL back_to_back k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                         k, tx, ready, exp_tx, exp_rdy);
            end
            if (k == FRAME_CYC + 1) start = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [7:0] rx;
        logic [7:0] want;
        int         gap;
        for (int f = 0; f < 8; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (tx !== 1'b1 || ready !== 1'b1) begin
                    failures++;
                    $display("FAIL random_gap frame=%0d tx=%b ready=%b expected tx=1 ready=1", f, tx, ready);
                end
            end
            d = 8'($urandom);
            exp_q.push_back(d);
            rx = 8'h00;
            @(negedge clk);
            data  = d;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            for (int k = 0; k <= FRAME_CYC; k++) begin
                @(negedge clk);
                if (k >= BAUD && k < 9 * BAUD && (k % BAUD) == BAUD / 2)
                    rx[k / BAUD - 1] = tx;
                checks++;
                if (tx !== model_tx(d, k) || ready !== model_ready(k)) begin
                    failures++;
                    $display("FAIL random frame=%0d d=%h k=%0d tx=%b ready=%b expected tx=%b ready=%b",
                             f, d, k, tx, ready, model_tx(d, k), model_ready(k));
                end
                start = (k < FRAME_CYC - 1) && ($urandom_range(0, 3) == 0);
                data  = 8'($urandom);
            end
            start = 1'b0;
            want = exp_q.pop_front();
            checks++;
            if (rx !== want) begin
                failures++;
                $display("FAIL random_decode frame=%0d got=%h expected=%h", f, rx, want);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(8'h55);
        test_data_change();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for 8N1 asynchronous frames: accepts a byte on a one-cycle start strobe, shifts it out LSB-first on a registered `tx` line at a fixed bit period, and reports idle/busy on `ready`. It sits under the command-sending controller, which loads one character per frame from ROM and waits for `ready` before the next.

## Interface
- `BAUD`, default 104 (`B115200` at 12 MHz): clock cycles per bit; legal range 2 to 65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `data`  in  8  byte to send; sampled only on the cycle a start is accepted.
- `start`  in  1  request strobe; a transmission begins when `start`=1 and `ready`=1 at a rising edge.
- `ready`  out  1  1 = idle, able to accept; 0 = frame in progress.
- `tx`  out  1  serial line, idle high; driven directly from a flip-flop.

## Operation
- Frame: start bit (0), `data[0]` … `data[7]`, stop bit (1); 10 bits total, each exactly `BAUD` cycles.
- States: IDLE (`ready`=1, `tx`=1) and BUSY (`ready`=0).
- IDLE → BUSY on an accepted start:
  - latch `data` into a 10-bit shift register {1, data, 0};
  - clear the bit-period counter and the bit counter.
- BUSY behaviour:
  - `tx` = shift register LSB;
  - at each bit-period end (counter = `BAUD`-1): shift right, fill with 1, increment the bit counter;
  - after the 10th bit period ends, return to IDLE.
- `start` while BUSY is ignored; the `data` input is don't-care while BUSY.
- `start` held high in IDLE starts one frame per acceptance. If it is still high when `ready` returns to 1, the next frame starts immediately.
- Reset (`rstn`=0) at any time, including mid-frame:
  - `ready`=1, `tx`=1, counters 0, shift register all ones;
  - the partial frame is abandoned and no tail bits are sent.

## Timing
- Reset values: `ready`=1, `tx`=1.
- Let E be the rising edge that accepts start. Immediately after E:
  - `ready`=0;
  - `tx`=0 (start bit).
  - The controller checks `ready` two edges after asserting start and relies on this.
- Bit n (0 = start bit, 9 = stop bit) occupies cycles E+n·`BAUD` through E+(n+1)·`BAUD`-1.
- `ready` returns to 1 after edge E+10·`BAUD`; it is low for exactly 10·`BAUD` cycles.
- Earliest next acceptance: edge E+10·`BAUD`+1. The stop bit is never shortened.
- No combinational path from inputs to `tx` or `ready`.
- Width rules:
  - bit-period counter is ceil(log2(`BAUD`)) bits, wrapping to 0 at `BAUD`-1;
  - bit counter is 4 bits, counting 0..9.

## Structure
- Shared package/header holds the baud divisor constants for 12 MHz: `B115200`=104, `B57600`=208, `B38400`=312, `B19200`=625, `B9600`=1250, `B4800`=2500, `B2400`=5000, `B1200`=10000, `B600`=20000, `B300`=40000.
- One sub-module, `baudgen_tx`:
  - parameter `BAUD`; inputs `clk`, `rstn`, `clk_ena`;
  - emits a one-cycle tick at each bit-period end;
  - held at count 0 while `clk_ena`=0, i.e. cleared when a frame starts.
- `uart_tx` contains the shift register, the bit counter and the IDLE/BUSY control.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles, release → `tx`=1 and `ready`=1, and they stay so with `start`=0 for 50 cycles.
- Single frame, `BAUD`=4, `data`=8'h55, 1-cycle start → `ready` falls the next cycle; `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; `ready`=1 exactly 40 cycles after acceptance.
- `data`=8'h0A; change `data` to 8'hFF one cycle after start → line decodes 0x0A (bits 0,1,0,1,0,0,0,0 after the start bit); the later input change has no effect.
- Start pulses at cycles 5 and 20 of a frame (`BAUD`=4) → ignored; exactly one frame observed, `ready` low 40 cycles.
- Reset mid-frame: assert `rstn`=0 during bit 3 → `tx`=1 and `ready`=1 asynchronously. A start after release sends a complete, correct frame.
- Back-to-back: `start` held high with `data`=8'h41 then 8'h42 → two frames, stop bit of the first a full 4 cycles, the second start bit one cycle after `ready` rises.
